// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares the single cache-bus memory port between the icache
// (fetch side) and the dcache (memory side). The winner keeps the grant for
// a whole burst. Its request passes straight through to the bridge, and the
// bridge responses are routed back to it. Beats are counted so that a
// length/last mismatch raises a one-cycle burst_err pulse.
//
// Optional feature: define CBUS_ARB_RR_EN to make ties in IDLE alternate
// between the masters (round robin). Without it, dcache always wins a tie.
module cbus_arbiter #(
  parameter  int LEN_W  = 4,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + 1 + 3 + 32 + STRB_W + DATA_W + LEN_W,
  localparam int RESP_W = 2 + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  ireq,
  output logic [RESP_W-1:0] iresp,
  input  logic [REQ_W-1:0]  dreq,
  output logic [RESP_W-1:0] dresp,
  output logic [REQ_W-1:0]  oreq,
  input  logic [RESP_W-1:0] oresp,
  output logic [1:0]        owner,
  output logic              burst_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beats;
  logic [LEN_W-1:0] granted_len;
  logic             i_valid;
  logic             d_valid;
  logic             resp_ready;
  logic             resp_last;
  logic             pick_d;

  assign i_valid    = ireq[REQ_W-1];
  assign d_valid    = dreq[REQ_W-1];
  assign resp_ready = oresp[RESP_W-1];
  assign resp_last  = oresp[RESP_W-2];
  assign owner      = state;

  // Length of the burst currently being served, taken from the held request
  assign granted_len = (state == BUSY_D) ? dreq[LEN_W-1:0] : ireq[LEN_W-1:0];

`ifdef CBUS_ARB_RR_EN
  // last_grant: 0 = icache, 1 = dcache; on a tie the other master wins
  logic last_grant;

  assign pick_d = d_valid && (!i_valid || !last_grant);

  // Remember which master took the most recent grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_d) begin
        last_grant <= 1'b1;
      end else if (i_valid) begin
        last_grant <= 1'b0;
      end
    end
  end
`else
  assign pick_d = d_valid;
`endif

  // Grant FSM, beat counter and registered burst error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beats     <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= 1'b0;
      unique case (state)
        IDLE: begin
          beats <= '0;
          if (pick_d) begin
            state <= BUSY_D;
          end else if (i_valid) begin
            state <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (resp_ready) begin
            beats <= beats + 1'b1;
            if ((resp_last && (beats != granted_len)) ||
                (!resp_last && (beats == granted_len))) begin
              burst_err <= 1'b1;
            end
            if (resp_last) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Route the owner's request out and the bridge response back to it
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    unique case (state)
      BUSY_I: begin
        oreq  = ireq;
        iresp = oresp;
      end
      BUSY_D: begin
        oreq  = dreq;
        dresp = oresp;
      end
      default: begin
        oreq  = '0;
      end
    endcase
  end

endmodule
